// File: rtl/spoc_bdi_preproc.sv
// SpoC-64 bdi/key pre-processor: decodes instruction and header words and passes data through.
// Optional protocol-error trap enabled by defining SPOC_PREPROC_ERR_EN.
module spoc_bdi_preproc #(
    parameter int KEY_WORDS = 4,
    parameter int LEN_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pdi_data,
    input  logic        pdi_valid,
    output logic        pdi_ready,
    input  logic [31:0] sdi_data,
    input  logic        sdi_valid,
    output logic        sdi_ready,
    output logic [31:0] key,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        key_update,
    output logic [31:0] bdi,
    output logic        bdi_valid,
    input  logic        bdi_ready,
    output logic [3:0]  bdi_type,
    output logic [2:0]  bdi_size,
    output logic        bdi_eot,
    output logic        bdi_eoi,
    output logic        decrypt,
    output logic        err
);

    localparam int KW_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

    localparam logic [3:0] OP_ACTKEY = 4'b0111;
    localparam logic [3:0] OP_ENC    = 4'b0010;
    localparam logic [3:0] OP_DEC    = 4'b0011;
    localparam logic [3:0] OP_LDKEY  = 4'b0100;

    typedef enum logic [2:0] {
        S_INST,
        S_SDI_INST,
        S_SDI_HDR,
        S_KEY,
        S_HDR,
        S_DATA
`ifdef SPOC_PREPROC_ERR_EN
        , S_ERR
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [KW_W-1:0]    kctr_q, kctr_d;
    logic               dec_q, dec_d;
    logic               kupd_q, kupd_d;
    logic [3:0]         type_q, type_d;
    logic               eoi_q, eoi_d;
    logic               eot_q, eot_d;
    logic               last_q, last_d;
    logic               run_q;
    logic               pdi_rdy;
    logic [2:0]         size_c;
    logic               last_word;
    logic [31:0]        mask;
    logic [3:0]         pdi_op;
    logic [3:0]         sdi_op;
`ifdef SPOC_PREPROC_ERR_EN
    logic               err_q, err_d;
`endif

    assign pdi_op    = pdi_data[31:28];
    assign sdi_op    = sdi_data[31:28];
    assign size_c    = (len_q >= LEN_W'(4)) ? 3'd4 : {1'b0, len_q[1:0]};
    assign last_word = (len_q <= LEN_W'(4));

    // Byte mask for a partial final word (valid bytes are MSB-first)
    always_comb begin
        mask = 32'hFFFF_FFFF;
        case (size_c)
            3'd1:    mask = 32'hFF00_0000;
            3'd2:    mask = 32'hFFFF_0000;
            3'd3:    mask = 32'hFFFF_FF00;
            default: mask = 32'hFFFF_FFFF;
        endcase
    end

    // Next-state and handshake/output decode
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        kctr_d    = kctr_q;
        dec_d     = dec_q;
        kupd_d    = kupd_q;
        type_d    = type_q;
        eoi_d     = eoi_q;
        eot_d     = eot_q;
        last_d    = last_q;
`ifdef SPOC_PREPROC_ERR_EN
        err_d     = err_q;
`endif
        pdi_rdy   = 1'b0;
        sdi_ready = 1'b0;
        key       = 32'h0;
        key_valid = 1'b0;
        bdi       = 32'h0;
        bdi_valid = 1'b0;
        bdi_type  = 4'h0;
        bdi_size  = 3'd0;
        bdi_eot   = 1'b0;
        bdi_eoi   = 1'b0;
        case (state_q)
            S_INST: begin
                pdi_rdy = 1'b1;
                if (pdi_valid && run_q) begin
                    if (pdi_op == OP_ACTKEY) begin
                        kupd_d  = 1'b1;
                        state_d = S_SDI_INST;
                    end else if (pdi_op == OP_ENC || pdi_op == OP_DEC) begin
                        dec_d   = pdi_op[0];
                        state_d = S_HDR;
                    end
`ifdef SPOC_PREPROC_ERR_EN
                    else if (pdi_op != OP_LDKEY) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
`endif
                end
            end
            S_SDI_INST: begin
                sdi_ready = 1'b1;
                if (sdi_valid) begin
                    if (sdi_op == OP_LDKEY) begin
                        state_d = S_SDI_HDR;
                    end
`ifdef SPOC_PREPROC_ERR_EN
                    else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
`endif
                end
            end
            S_SDI_HDR: begin
                sdi_ready = 1'b1;
                if (sdi_valid) begin
                    state_d = S_KEY;
                end
            end
            S_KEY: begin
                key       = sdi_data;
                key_valid = sdi_valid;
                sdi_ready = key_ready;
                if (sdi_valid && key_ready) begin
                    if (kctr_q == KW_W'(KEY_WORDS - 1)) begin
                        kctr_d  = '0;
                        kupd_d  = 1'b0;
                        state_d = S_INST;
                    end else begin
                        kctr_d = kctr_q + 1'b1;
                    end
                end
            end
            S_HDR: begin
                pdi_rdy = 1'b1;
                if (pdi_valid) begin
                    type_d = pdi_data[31:28];
                    eoi_d  = pdi_data[26];
                    eot_d  = pdi_data[25];
                    last_d = pdi_data[24];
                    len_d  = pdi_data[LEN_W-1:0];
                    if (pdi_data[LEN_W-1:0] == '0) begin
                        state_d = pdi_data[24] ? S_INST : S_HDR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                pdi_rdy   = bdi_ready;
                bdi_valid = pdi_valid;
                bdi       = pdi_data & mask;
                bdi_type  = type_q;
                bdi_size  = size_c;
                bdi_eot   = last_word & eot_q;
                bdi_eoi   = last_word & eoi_q;
                if (pdi_valid && bdi_ready) begin
                    if (last_word) begin
                        len_d   = '0;
                        state_d = last_q ? S_INST : S_HDR;
                    end else begin
                        len_d = len_q - LEN_W'(size_c);
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // pdi_ready stays low while reset is asserted and for the first cycle after
    assign pdi_ready  = pdi_rdy & run_q;
    assign key_update = kupd_q;
    assign decrypt    = dec_q;
`ifdef SPOC_PREPROC_ERR_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

    // State and context registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INST;
            len_q   <= '0;
            kctr_q  <= '0;
            dec_q   <= 1'b0;
            kupd_q  <= 1'b0;
            type_q  <= 4'h0;
            eoi_q   <= 1'b0;
            eot_q   <= 1'b0;
            last_q  <= 1'b0;
            run_q   <= 1'b0;
`ifdef SPOC_PREPROC_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            kctr_q  <= kctr_d;
            dec_q   <= dec_d;
            kupd_q  <= kupd_d;
            type_q  <= type_d;
            eoi_q   <= eoi_d;
            eot_q   <= eot_d;
            last_q  <= last_d;
            run_q   <= 1'b1;
`ifdef SPOC_PREPROC_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule
